stage_ma: RTL
=============

Name: stage_ma

Overview:
- Memory-access stage. Sits directly downstream of the EX/MA pipeline register and consumes its pc, rd, result, data2 and io_ops outputs.
- Performs loads, stores, LR/SC and AMO read-modify-write over a single-outstanding data bus.
- Drives the MA/WB register inputs and holds the pipeline stalled while an access is in flight.

Parameters:
- RESV_GRAIN, 3, log2 bytes of the LR/SC reservation granule; address bits [63:RESV_GRAIN] are compared.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear  in  1  flush: abort the idle-state op, drop the reservation
- pc_in  in  `XMSB+1  pc from EX/MA
- rd_in  in  5  destination register from EX/MA
- result_in  in  64  ALU result; the effective address for memory ops
- data2_in  in  64  store data / AMO operand
- io_ops_in  io_ops.dst  -  load_op, store_op, amo_*_op, lr_op, sc_op, size[2:0] (bit2 = unsigned, [1:0] = log2 bytes), mask[7:0] byte enables
- pc_out  out  `XMSB+1  to MA/WB
- rd_out  out  5  to MA/WB
- result_out  out  64  load/AMO old value, SC status, or result_in pass-through
- stall_req  out  1  holds upstream stages and the EX/MA register
- bus_req  out  1  access request
- bus_we  out  1  write
- bus_addr  out  64  8-byte-aligned address
- bus_wdata  out  64  lane-aligned write data
- bus_wmask  out  8  byte enables
- bus_rdy  in  1  access complete this cycle; bus_rdata valid for reads
- bus_rdata  in  64  read data

Behaviour:
- Reset: FSM IDLE, reservation invalid. bus_req, bus_we, bus_wmask and stall_req are 0. pc_out, rd_out and result_out are combinational from the inputs/datapath, so they need no reset value.
- FSM states and transitions:
  - IDLE, memory op present: go to RD (load, LR, AMO), WR (store), or RD-less SC handling.
  - IDLE, no op: result_out = result_in, stall_req = 0.
  - RD: waits for bus_rdy.
  - WR: waits for bus_rdy.
  - AMO_WR: waits for bus_rdy.
- Bus: bus_req is asserted from entry to a wait state until bus_rdy is sampled high.
  - Address, we, wdata and wmask are stable while bus_req is high.
  - bus_addr = {result_in[63:3], 3'b0}.
  - wdata = data2_in << (8 × result_in[2:0]).
  - wmask = io_ops_in.mask.
- stall_req = 1 in every non-IDLE state, and in IDLE when starting an op. It drops combinationally in the cycle bus_rdy completes the final access, so the EX/MA register advances next edge.
- Load: bytes are extracted from rdata >> (8 × addr[2:0]), masked to 1/2/4/8 bytes, then sign- or zero-extended per size[2]. Latency equals bus latency; result_out is valid in the bus_rdy cycle.
- Store: result_out = result_in. The store clears the reservation if its granule matches.
- LR: performs a load and sets the reservation to {valid, addr granule}.
- SC:
  - Reservation valid and granule matches: perform the write, result_out = 0.
  - Otherwise: no bus access, result_out = 1, complete in IDLE with no stall.
  - The reservation is invalidated in both cases.
- AMO (add, swap, xor, or, and, min, max, minu, maxu):
  - RD captures the old value; AMO_WR writes new = op(old, data2) at the same address and mask.
  - Word ops (size[1:0]=2) compute on 32 bits; min/max are signed, minu/maxu unsigned.
  - result_out = old value, sign-extended for word ops, held in a register until AMO_WR completes.
- Simultaneous events:
  - bus_rdy in the same cycle as entry cannot occur: requests start at the next cycle.
  - clear while in IDLE suppresses starting an op.
  - clear while in a wait state is ignored until completion; no bus transaction is ever abandoned. The reservation is still invalidated.
  - rst mid-transaction returns to IDLE immediately and drops bus_req.
- Misaligned addresses are not checked here; EX raises the trap upstream.

Decomposition:
- Package ma_pkg: the FSM state enum (IDLE, RD, WR, AMO_WR), size encodings (SZ_B/H/W/D, SZ_UNS bit), and the amo_op_t one-hot decode.
- One sub-module: amo_alu. Combinational; takes old, operand, word flag and op; produces new value.

Test Plan:
- Load byte, signed: addr 0x1003, rdata 0x0000_0000_8000_0000 with byte 3 = 0x80, size 0 -> result_out 0xFFFF_FFFF_FFFF_FF80; stall_req high until the bus_rdy cycle. Repeat with size 4 -> 0x80.
- Store half: addr 0x2006, data2 0xABCD, mask 0xC0 -> bus_we = 1, bus_addr 0x2000, wdata 0xABCD_0000_0000_0000, wmask 0xC0; bus_req held across 3 cycles of bus_rdy = 0.
- LR, store, SC:
  - LR at 0x3000, then SC at 0x3000 -> result_out 0 and one write.
  - LR, then store to 0x3004, then SC -> result_out 1 and no bus_req.
- amoadd.w: addr 0x4000, old 0x7FFF_FFFF, data2 1 -> two transactions; written value 0x8000_0000; result_out 0x0000_0000_7FFF_FFFF.
- amomin.d vs amominu.d: old 0xFFFF_FFFF_FFFF_FFFF, data2 1 -> signed writes old value; unsigned writes 1.
- Reset and clear: rst asserted in RD -> next cycle bus_req = 0, FSM IDLE. clear in IDLE with load_op set -> no bus_req, reservation cleared.

Source files
------------

// File: rtl/ma_pkg.sv
// Shared types for the memory-access stage: FSM states, access-size encodings,
// AMO operation decode and load byte-extraction helpers.
package ma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        AMO_WR
    } ma_state_t;

    localparam logic [1:0]  SZ_B   = 2'd0;
    localparam logic [1:0]  SZ_H   = 2'd1;
    localparam logic [1:0]  SZ_W   = 2'd2;
    localparam logic [1:0]  SZ_D   = 2'd3;
    localparam int unsigned SZ_UNS = 2;

    typedef enum logic [8:0] {
        AMO_NONE = 9'h000,
        AMO_ADD  = 9'h001,
        AMO_SWAP = 9'h002,
        AMO_XOR  = 9'h004,
        AMO_OR   = 9'h008,
        AMO_AND  = 9'h010,
        AMO_MIN  = 9'h020,
        AMO_MAX  = 9'h040,
        AMO_MINU = 9'h080,
        AMO_MAXU = 9'h100
    } amo_op_t;

    function automatic amo_op_t amo_decode(input logic add_op, input logic swap_op,
                                           input logic xor_op, input logic or_op,
                                           input logic and_op, input logic min_op,
                                           input logic max_op, input logic minu_op,
                                           input logic maxu_op);
        amo_op_t op;
        if (add_op)       op = AMO_ADD;
        else if (swap_op) op = AMO_SWAP;
        else if (xor_op)  op = AMO_XOR;
        else if (or_op)   op = AMO_OR;
        else if (and_op)  op = AMO_AND;
        else if (min_op)  op = AMO_MIN;
        else if (max_op)  op = AMO_MAX;
        else if (minu_op) op = AMO_MINU;
        else if (maxu_op) op = AMO_MAXU;
        else              op = AMO_NONE;
        return op;
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // data is already shifted so the addressed byte sits in lane 0
    function automatic logic [63:0] load_extend(input logic [63:0] data,
                                                input logic [2:0]  size);
        logic [63:0] r;
        case (size[1:0])
            SZ_B:    r = size[SZ_UNS] ? {56'd0, data[7:0]}  : {{56{data[7]}}, data[7:0]};
            SZ_H:    r = size[SZ_UNS] ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
            SZ_W:    r = size[SZ_UNS] ? {32'd0, data[31:0]} : sext32(data[31:0]);
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/io_ops.sv
// Decoded memory-operation controls carried from the EX/MA register.
interface io_ops;
    logic       load_op;
    logic       store_op;
    logic       lr_op;
    logic       sc_op;
    logic       amo_add_op;
    logic       amo_swap_op;
    logic       amo_xor_op;
    logic       amo_or_op;
    logic       amo_and_op;
    logic       amo_min_op;
    logic       amo_max_op;
    logic       amo_minu_op;
    logic       amo_maxu_op;
    logic [2:0] size;
    logic [7:0] mask;

    modport src (
        output load_op, store_op, lr_op, sc_op, amo_add_op, amo_swap_op, amo_xor_op,
               amo_or_op, amo_and_op, amo_min_op, amo_max_op, amo_minu_op, amo_maxu_op,
               size, mask
    );

    modport dst (
        input load_op, store_op, lr_op, sc_op, amo_add_op, amo_swap_op, amo_xor_op,
              amo_or_op, amo_and_op, amo_min_op, amo_max_op, amo_minu_op, amo_maxu_op,
              size, mask
    );
endinterface

// File: rtl/amo_alu.sv
// Combinational AMO arithmetic: new = op(old, operand), on 32 or 64 bits.
module amo_alu
    import ma_pkg::*;
(
    input  logic [63:0] old_val,
    input  logic [63:0] operand,
    input  logic        word,
    input  amo_op_t     op,
    output logic [63:0] new_val
);

    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        lt_s;
    logic        lt_u;

    // Sign-extending both word operands keeps signed and unsigned ordering intact.
    always_comb begin
        a    = word ? sext32(old_val[31:0]) : old_val;
        b    = word ? sext32(operand[31:0]) : operand;
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        r    = b;
        unique case (op)
            AMO_ADD:  r = a + b;
            AMO_SWAP: r = b;
            AMO_XOR:  r = a ^ b;
            AMO_OR:   r = a | b;
            AMO_AND:  r = a & b;
            AMO_MIN:  r = lt_s ? a : b;
            AMO_MAX:  r = lt_s ? b : a;
            AMO_MINU: r = lt_u ? a : b;
            AMO_MAXU: r = lt_u ? b : a;
            default:  r = b;
        endcase
        new_val = word ? sext32(r[31:0]) : r;
    end

endmodule

// File: rtl/stage_ma.sv
// Memory-access pipeline stage: loads, stores, LR/SC and AMO read-modify-write over a
// single-outstanding data bus, stalling the pipe while an access is in flight.
`ifndef XMSB
`define XMSB 63
`endif

module stage_ma
    import ma_pkg::*;
#(
    parameter int unsigned RESV_GRAIN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [`XMSB:0]  pc_in,
    input  logic [4:0]      rd_in,
    input  logic [63:0]     result_in,
    input  logic [63:0]     data2_in,
    io_ops.dst              io_ops_in,
    output logic [`XMSB:0]  pc_out,
    output logic [4:0]      rd_out,
    output logic [63:0]     result_out,
    output logic            stall_req,
    output logic            bus_req,
    output logic            bus_we,
    output logic [63:0]     bus_addr,
    output logic [63:0]     bus_wdata,
    output logic [7:0]      bus_wmask,
    input  logic            bus_rdy,
    input  logic [63:0]     bus_rdata
);

    localparam int unsigned GW = 64 - RESV_GRAIN;

    ma_state_t   state_q, state_d;
    logic        resv_valid_q, resv_valid_d;
    logic [GW-1:0] resv_addr_q, resv_addr_d;
    logic [63:0] amo_old_q, amo_old_d;

    amo_op_t     amo_op;
    logic        is_amo;
    logic        amo_word;
    logic [GW-1:0] granule;
    logic        resv_hit;
    logic [5:0]  lane_shift;
    logic [63:0] rd_shifted;
    logic [63:0] load_val;
    logic [63:0] amo_old_ext;
    logic [63:0] amo_new;

    assign amo_op = amo_decode(io_ops_in.amo_add_op, io_ops_in.amo_swap_op,
                               io_ops_in.amo_xor_op, io_ops_in.amo_or_op,
                               io_ops_in.amo_and_op, io_ops_in.amo_min_op,
                               io_ops_in.amo_max_op, io_ops_in.amo_minu_op,
                               io_ops_in.amo_maxu_op);

    assign is_amo      = (amo_op != AMO_NONE);
    assign amo_word    = (io_ops_in.size[1:0] == SZ_W);
    assign granule     = result_in[63:RESV_GRAIN];
    assign resv_hit    = resv_valid_q && (resv_addr_q == granule);
    assign lane_shift  = {result_in[2:0], 3'b000};
    assign rd_shifted  = bus_rdata >> lane_shift;
    assign load_val    = load_extend(rd_shifted, io_ops_in.size);
    assign amo_old_ext = amo_word ? sext32(rd_shifted[31:0]) : rd_shifted;

    amo_alu u_amo_alu (
        .old_val (amo_old_q),
        .operand (data2_in),
        .word    (amo_word),
        .op      (amo_op),
        .new_val (amo_new)
    );

    always_comb begin
        state_d      = state_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        amo_old_d    = amo_old_q;
        stall_req    = 1'b0;
        result_out   = result_in;

        unique case (state_q)
            IDLE: begin
                if (!clear) begin
                    if (io_ops_in.load_op || io_ops_in.lr_op || is_amo) begin
                        state_d   = RD;
                        stall_req = 1'b1;
                    end else if (io_ops_in.store_op) begin
                        state_d   = WR;
                        stall_req = 1'b1;
                        if (resv_hit) resv_valid_d = 1'b0;
                    end else if (io_ops_in.sc_op) begin
                        resv_valid_d = 1'b0;
                        if (resv_hit) begin
                            state_d    = WR;
                            stall_req  = 1'b1;
                            result_out = 64'd0;
                        end else begin
                            result_out = 64'd1;
                        end
                    end
                    if (io_ops_in.lr_op) begin
                        resv_valid_d = 1'b1;
                        resv_addr_d  = granule;
                    end
                end
            end
            RD: begin
                result_out = load_val;
                if (bus_rdy) begin
                    if (is_amo) begin
                        amo_old_d = amo_old_ext;
                        state_d   = AMO_WR;
                        stall_req = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    stall_req = 1'b1;
                end
            end
            WR: begin
                // Only a successful SC ever reaches WR with sc_op set.
                if (io_ops_in.sc_op) result_out = 64'd0;
                stall_req = !bus_rdy;
                if (bus_rdy) state_d = IDLE;
            end
            AMO_WR: begin
                result_out = amo_old_q;
                stall_req  = !bus_rdy;
                if (bus_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear) resv_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            amo_old_q    <= '0;
        end else begin
            state_q      <= state_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            amo_old_q    <= amo_old_d;
        end
    end

    assign pc_out    = pc_in;
    assign rd_out    = rd_in;
    assign bus_req   = (state_q != IDLE);
    assign bus_we    = (state_q == WR) || (state_q == AMO_WR);
    assign bus_addr  = {result_in[63:3], 3'b000};
    assign bus_wdata = ((state_q == AMO_WR) ? amo_new : data2_in) << lane_shift;
    assign bus_wmask = bus_req ? io_ops_in.mask : 8'h00;

endmodule
